// File: rtl/grn_attractor_ctrl.sv
// Sequencer that sweeps every initial state of a gene-regulatory-network node array,
// finds its attractor with Floyd tortoise/hare stepping, then measures the attractor period.
module grn_attractor_ctrl #(
    parameter int NODES  = 4,
    parameter int STEP_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [STEP_W-1:0] max_steps,
    output logic              reset_nos,
    output logic [NODES-1:0]  init_state,
    output logic              start_s0,
    output logic              start_s1,
    input  logic [NODES-1:0]  s0_state,
    input  logic [NODES-1:0]  s1_state,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [NODES-1:0]  res_init,
    output logic [NODES-1:0]  res_attr,
    output logic [STEP_W-1:0] res_meet,
    output logic [STEP_W-1:0] res_period,
    output logic              res_tmo,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_STEP, S_CMP, S_PSTEP, S_PCMP, S_REPORT, S_DONE
    } state_t;

    state_t            state, state_nx;
    logic [STEP_W-1:0] max_q;
    logic [STEP_W-1:0] k_q;
    logic [STEP_W-1:0] p_q;
    logic [NODES-1:0]  cur_init;

    logic meet_hit, k_lim, per_hit, p_lim, accept, last_init;

    function automatic logic [STEP_W-1:0] sat_inc(input logic [STEP_W-1:0] v,
                                                  input logic [STEP_W-1:0] lim);
        return (v < lim) ? v + STEP_W'(1) : v;
    endfunction

    function automatic logic [STEP_W-1:0] floor_one(input logic [STEP_W-1:0] v);
        return (v == '0) ? STEP_W'(1) : v;
    endfunction

    // Odd step counts leave the tortoise one pass ahead of f^(k/2), so only even k >= 2 may compare
    assign meet_hit   = !k_q[0] && (k_q >= STEP_W'(2)) && (s0_state == s1_state);
    assign k_lim      = k_q >= max_q;
    assign per_hit    = s1_state == res_attr;
    assign p_lim      = p_q >= max_q;
    assign accept     = (state == S_REPORT) && res_valid && res_ready;
    assign last_init  = &cur_init;
    assign init_state = cur_init;

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (start) state_nx = S_LOAD;
            S_LOAD:   state_nx = S_STEP;
            S_STEP:   state_nx = S_CMP;
            S_CMP: begin
                if (meet_hit)   state_nx = S_PSTEP;
                else if (k_lim) state_nx = S_REPORT;
                else            state_nx = S_STEP;
            end
            S_PSTEP:  state_nx = S_PCMP;
            S_PCMP:   state_nx = (per_hit || p_lim) ? S_REPORT : S_PSTEP;
            S_REPORT: if (accept) state_nx = last_init ? S_DONE : S_LOAD;
            S_DONE:   state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            max_q      <= '0;
            k_q        <= '0;
            p_q        <= '0;
            cur_init   <= '0;
            reset_nos  <= 1'b0;
            start_s0   <= 1'b0;
            start_s1   <= 1'b0;
            res_valid  <= 1'b0;
            res_init   <= '0;
            res_attr   <= '0;
            res_meet   <= '0;
            res_period <= '0;
            res_tmo    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state <= state_nx;
            // Strobes and status are decoded from the next state so they line up with the state they belong to
            reset_nos <= (state_nx == S_LOAD);
            start_s0  <= (state_nx == S_STEP);
            start_s1  <= (state_nx == S_STEP) || (state_nx == S_PSTEP);
            res_valid <= (state_nx == S_REPORT);
            busy      <= (state_nx != S_IDLE) && (state_nx != S_DONE);
            done      <= (state_nx == S_DONE);

            case (state)
                S_IDLE: begin
                    if (start) begin
                        max_q    <= floor_one(max_steps);
                        cur_init <= '0;
                    end
                end
                S_LOAD: begin
                    k_q        <= '0;
                    p_q        <= '0;
                    res_init   <= cur_init;
                    res_attr   <= '0;
                    res_meet   <= '0;
                    res_period <= '0;
                    res_tmo    <= 1'b0;
                end
                S_STEP:  k_q <= sat_inc(k_q, max_q);
                S_CMP: begin
                    if (meet_hit) begin
                        res_meet <= k_q;
                        res_attr <= s0_state;
                        p_q      <= '0;
                    end else if (k_lim) begin
                        res_tmo    <= 1'b1;
                        res_period <= '0;
                    end
                end
                S_PSTEP: p_q <= sat_inc(p_q, max_q);
                S_PCMP: begin
                    if (per_hit) begin
                        res_period <= p_q;
                    end else if (p_lim) begin
                        res_tmo    <= 1'b1;
                        res_period <= '0;
                    end
                end
                S_REPORT: begin
                    if (accept && !last_init) cur_init <= cur_init + NODES'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_grn_attractor_ctrl.sv
// Bench for grn_attractor_ctrl: behavioural node array (identity / inverter / ring nets)
// and a result scoreboard filled from a reference Floyd model at each sweep start.
module tb_grn_attractor_ctrl;
    localparam int NODES  = 3;
    localparam int STEP_W = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              res_ready = 1'b0;
    logic [STEP_W-1:0] max_steps = '0;
    logic              reset_nos, start_s0, start_s1, res_valid, res_tmo, busy, done;
    logic [NODES-1:0]  init_state, res_init, res_attr;
    logic [NODES-1:0]  s0_state, s1_state;
    logic [STEP_W-1:0] res_meet, res_period;
    logic              pass_bit;

    int checks = 0;
    int errors = 0;
    int net_sel = 0;
    int overlap = 0;

    typedef struct {
        logic [NODES-1:0] init;
        logic [NODES-1:0] attr;
        int               meet;
        int               period;
        bit               tmo;
    } res_t;

    res_t sb[$];
    int               got_meet[8];
    int               got_period[8];
    logic [NODES-1:0] got_attr[8];

    always #5 clk = ~clk;

    grn_attractor_ctrl #(.NODES(NODES), .STEP_W(STEP_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .max_steps(max_steps),
        .reset_nos(reset_nos), .init_state(init_state),
        .start_s0(start_s0), .start_s1(start_s1),
        .s0_state(s0_state), .s1_state(s1_state),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_init(res_init), .res_attr(res_attr), .res_meet(res_meet),
        .res_period(res_period), .res_tmo(res_tmo), .busy(busy), .done(done)
    );

    function automatic logic [NODES-1:0] f_net(input int net, input logic [NODES-1:0] s);
        case (net)
            0:       return s;
            1:       return ~s;
            default: return {s[NODES-2:0], s[NODES-1]};
        endcase
    endfunction

    // Node array: hare advances every pulse, tortoise only on odd start_s0 pulses
    always @(posedge clk) begin
        if (reset_nos) begin
            s0_state <= init_state;
            s1_state <= init_state;
            pass_bit <= 1'b0;
        end else begin
            if (start_s1) s1_state <= f_net(net_sel, s1_state);
            if (start_s0) begin
                pass_bit <= ~pass_bit;
                if (!pass_bit) s0_state <= f_net(net_sel, s0_state);
            end
        end
    end

    always @(negedge clk) begin
        if (reset_nos && (start_s0 || start_s1)) overlap <= overlap + 1;
    end

    function automatic res_t model(input int net, input logic [NODES-1:0] x, input int mx);
        res_t r;
        int lim;
        logic [NODES-1:0] t, h;
        bit found;
        lim = (mx == 0) ? 1 : mx;
        r.init = x; r.attr = '0; r.meet = 0; r.period = 0; r.tmo = 0;
        t = x; h = x; found = 0;
        for (int k = 1; k <= lim && !found; k++) begin
            h = f_net(net, h);
            if (k % 2 == 1) t = f_net(net, t);
            if (k % 2 == 0 && t == h) begin found = 1; r.meet = k; r.attr = t; end
        end
        if (!found) begin r.tmo = 1; return r; end
        found = 0;
        for (int p = 1; p <= lim && !found; p++) begin
            h = f_net(net, h);
            if (h == r.attr) begin found = 1; r.period = p; end
        end
        if (!found) r.tmo = 1;
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_reset_nos"},  32'(reset_nos),  32'd0);
        check({tag, "_start_s0"},   32'(start_s0),   32'd0);
        check({tag, "_start_s1"},   32'(start_s1),   32'd0);
        check({tag, "_init_state"}, 32'(init_state), 32'd0);
        check({tag, "_res_valid"},  32'(res_valid),  32'd0);
        check({tag, "_res_fields"}, 32'({res_init, res_attr, res_meet, res_period, res_tmo}), 32'd0);
        check({tag, "_busy"},       32'(busy),       32'd0);
        check({tag, "_done"},       32'(done),       32'd0);
    endtask

    task automatic run_sweep(input int net, input int mx, input int stall_at);
        res_t e;
        int cyc;
        bit stable;
        logic [2*NODES+2*STEP_W:0] snap;
        net_sel   = net;
        max_steps = STEP_W'(mx);
        for (int x = 0; x < 8; x++) sb.push_back(model(net, NODES'(x), mx));
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        check("first_load", 32'({reset_nos, init_state}), 32'({1'b1, 3'b000}));
        for (int n = 0; n < 8; n++) begin
            cyc = 0;
            while (!res_valid && cyc < 1000) begin @(negedge clk); cyc++; end
            check("res_valid_seen", 32'(res_valid), 32'd1);
            if (!res_valid) break;
            e = sb.pop_front();
            if (n == stall_at) begin
                snap   = {res_init, res_attr, res_meet, res_period, res_tmo};
                stable = 1;
                for (int i = 0; i < 20; i++) begin
                    start = (i == 5);
                    @(negedge clk);
                    if ({res_init, res_attr, res_meet, res_period, res_tmo} !== snap ||
                        !res_valid || reset_nos || start_s0 || start_s1) stable = 0;
                end
                start = 1'b0;
                check("stall_stable", 32'(stable), 32'd1);
            end
            check("res_init",   32'(res_init),   32'(e.init));
            check("res_tmo",    32'(res_tmo),    32'(e.tmo));
            check("res_period", 32'(res_period), 32'(e.period));
            if (!e.tmo) begin
                check("res_meet", 32'(res_meet), 32'(e.meet));
                check("res_attr", 32'(res_attr), 32'(e.attr));
            end
            got_meet[res_init]   = int'(res_meet);
            got_period[res_init] = int'(res_period);
            got_attr[res_init]   = res_attr;
            res_ready = 1'b1;
            @(negedge clk);
            res_ready = 1'b0;
            check("valid_drop", 32'(res_valid), 32'd0);
            if (n < 7) begin
                check("next_load", 32'(reset_nos), 32'd1);
                check("next_init", 32'(init_state), 32'(e.init) + 32'd1);
            end else begin
                check("done_pulse", 32'(done), 32'd1);
            end
        end
        sb.delete();
        @(negedge clk);
        check("done_clear", 32'(done), 32'd0);
        check("idle_busy",  32'(busy), 32'd0);
    endtask

    initial begin
        int cyc;
        repeat (3) @(negedge clk);
        check_quiet("reset");
        rst_n = 1'b1;

        res_ready = 1'b1;
        repeat (3) @(negedge clk);
        res_ready = 1'b0;
        check("ready_no_valid", 32'({res_valid, busy, reset_nos}), 32'd0);

        // Identity net with a 20-cycle stall on the third result
        run_sweep(0, 50, 2);
        check("id_meet_5",   32'(got_meet[5]),   32'd2);
        check("id_period_5", 32'(got_period[5]), 32'd1);
        check("id_attr_6",   32'(got_attr[6]),   32'd6);

        run_sweep(1, 50, -1);
        check("inv_period_0", 32'(got_period[0]), 32'd2);
        check("inv_attr_1",   32'(got_attr[1]),   32'd1);

        run_sweep(2, 50, -1);
        check("ring_period_1", 32'(got_period[1]), 32'd3);
        check("ring_period_0", 32'(got_period[0]), 32'd1);
        check("ring_period_7", 32'(got_period[7]), 32'd1);

        run_sweep(1, 1, -1);
        run_sweep(0, 0, -1);

        // Abort mid-sweep while the hare is stepping alone
        net_sel   = 1;
        max_steps = 16'd50;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        cyc = 0;
        while (!(start_s1 && !start_s0) && cyc < 200) begin @(negedge clk); cyc++; end
        check("pstep_reached", 32'(start_s1 && !start_s0), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check_quiet("abort");
        rst_n = 1'b1;
        run_sweep(0, 50, -1);

        check("strobe_overlap", 32'(overlap), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
